// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide execute unit with pipeline stall and one-cycle write-back.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply for MUL* ops.
//
// state | meaning
// IDLE  | waiting for an M-op; start is combinational and raises stallreq_o
// CALC  | one shift-add or restoring-divide iteration per cycle, XLEN cycles
// DONE  | sign-corrected result on reg_w*_o for one cycle, then back to IDLE
module exe_muldiv #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [31:0]        inst_i,
  input  logic [XLEN-1:0]    op1_i,
  input  logic [XLEN-1:0]    op2_i,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  input  logic               flush_i,
  output logic               stallreq_o,
  output logic               busy_o,
  output logic               reg_we_o,
  output logic [RADDR_W-1:0] reg_waddr_o,
  output logic [XLEN-1:0]    reg_wdata_o
);

  localparam int CW = $clog2(XLEN);
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]        cnt_q;
  logic [2*XLEN-1:0]    acc_q;
  logic [XLEN-1:0]      m_q;
  logic                 mul_q, hi_q, neg_q;
  logic [RADDR_W-1:0]   waddr_q;

  logic [2:0]      f3;
  logic            is_mop, start, in_mul, sa_en, sb_en, sa, sb;
  logic            div_zero, div_ovf, special, hi_sel, neg_sel;
  logic [XLEN-1:0] abs_a, abs_b, special_val;
  logic [2*XLEN-1:0] prod_fast;
  logic            unused_inst;

  assign f3          = inst_i[14:12];
  assign is_mop      = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
  assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};
  // rst_i gates start so every output reads 0 while reset is held
  assign start       = !rst_i && valid_i && is_mop && (state_q == IDLE) && !flush_i;

  assign in_mul = !f3[2];
  assign sa_en  = in_mul ? (f3[1:0] == 2'b01 || f3[1:0] == 2'b10) : !f3[0];
  assign sb_en  = in_mul ? (f3[1:0] == 2'b01) : !f3[0];
  assign sa     = sa_en & op1_i[XLEN-1];
  assign sb     = sb_en & op2_i[XLEN-1];
  assign abs_a  = sa ? -op1_i : op1_i;
  assign abs_b  = sb ? -op2_i : op2_i;

  assign div_zero    = !in_mul && (op2_i == '0);
  assign div_ovf     = !in_mul && !f3[0] && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
  assign special     = div_zero | div_ovf;
  assign special_val = div_zero ? (f3[1] ? op1_i : '1) : (f3[1] ? '0 : op1_i);
  assign hi_sel      = in_mul ? (f3[1:0] != 2'b00) : f3[1];
  // remainder follows the dividend sign; everything else follows sa^sb
  assign neg_sel     = (!in_mul && f3[1]) ? sa : (sa ^ sb);
  assign prod_fast   = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};

  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_next, div_next, acc_neg;
  logic [XLEN-1:0]   word_mul, word_div_raw, word_div, result;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff     = rem_sh - {1'b0, m_q};
  assign div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};

  assign acc_neg      = neg_q ? -acc_q : acc_q;
  assign word_mul     = hi_q ? acc_neg[2*XLEN-1:XLEN] : acc_neg[XLEN-1:0];
  assign word_div_raw = hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign word_div     = neg_q ? -word_div_raw : word_div_raw;
  assign result       = mul_q ? word_mul : word_div;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      mul_q   <= 1'b0;
      hi_q    <= 1'b0;
      neg_q   <= 1'b0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        waddr_q <= reg_waddr_i;
        mul_q   <= in_mul;
        hi_q    <= special ? 1'b0 : hi_sel;
        neg_q   <= special ? 1'b0 : neg_sel;
        cnt_q   <= '0;
        if (special) begin
          acc_q <= {{XLEN{1'b0}}, special_val};
        end else if (FAST_MUL && in_mul) begin
          acc_q <= prod_fast;
        end else if (in_mul) begin
          acc_q <= {{XLEN{1'b0}}, abs_b};
          m_q   <= abs_a;
        end else begin
          acc_q <= {{XLEN{1'b0}}, abs_a};
          m_q   <= abs_b;
        end
      end else if (state_q == CALC) begin
        acc_q <= mul_q ? mul_next : div_next;
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    stallreq_o  = start;
    reg_we_o    = 1'b0;
    reg_waddr_o = '0;
    reg_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (special || (FAST_MUL && in_mul)) ? DONE : CALC;
      end
      CALC: begin
        stallreq_o = !flush_i;
        if (flush_i)                          state_d = IDLE;
        else if (cnt_q == CW'(XLEN - 1))      state_d = DONE;
      end
      DONE: begin
        state_d     = IDLE;
        reg_we_o    = !flush_i && (waddr_q != '0);
        reg_waddr_o = waddr_q;
        reg_wdata_o = result;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed RV32M cases, reset/flush aborts,
// then randomized ops against an arithmetic reference model.
module tb_exe_muldiv;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               valid_i;
  logic [31:0]        inst_i;
  logic [XLEN-1:0]    op1_i, op2_i;
  logic [RADDR_W-1:0] reg_waddr_i;
  logic               flush_i;
  logic               stallreq_o, busy_o, reg_we_o;
  logic [RADDR_W-1:0] reg_waddr_o;
  logic [XLEN-1:0]    reg_wdata_o;

  int n_chk = 0;
  int n_pass = 0;
  int we_cnt = 0;

  exe_muldiv #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .inst_i(inst_i),
    .op1_i(op1_i), .op2_i(op2_i), .reg_waddr_i(reg_waddr_i), .flush_i(flush_i),
    .stallreq_o(stallreq_o), .busy_o(busy_o), .reg_we_o(reg_we_o),
    .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
  );

  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) if (reg_we_o) we_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    int ia = a;
    int ib = b;
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return XLEN + 1;
`endif
    end
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    logic [31:0] exp_val = ref_model(f3, a, b);
    int exp_lat = ref_lat(f3, a, b);
    int k = 0;
    int st = 0;
    bit done = 0;
    @(posedge clk_i); #1;
    valid_i = 1'b1; inst_i = mk_inst(f3, wa); op1_i = a; op2_i = b; reg_waddr_i = wa;
    @(negedge clk_i);
    if (stallreq_o) st++;
    @(posedge clk_i); #1;
    valid_i = 1'b0; op1_i = $urandom; op2_i = $urandom; reg_waddr_i = 5'($urandom);
    while (!done && k < 40) begin
      @(negedge clk_i); k++;
      if (busy_o && !stallreq_o) begin
        done = 1;
        chk($sformatf("lat f3=%0d", f3), k, exp_lat);
        chk($sformatf("we f3=%0d wa=%0d", f3, wa), reg_we_o, wa != 0);
        chk("waddr", reg_waddr_o, wa);
        chk($sformatf("wdata f3=%0d a=%h b=%h", f3, a, b), reg_wdata_o, exp_val);
      end else if (stallreq_o) st++;
      else break;
    end
    chk("done_seen", done, 1);
    chk("stall_cycles", st, exp_lat);
  endtask

  task automatic abort_test(input bit use_rst);
    int we0;
    @(posedge clk_i); #1;
    valid_i = 1'b1; inst_i = mk_inst(3'd4, 5'd5); op1_i = 32'hFFFF_FFF9; op2_i = 32'd2; reg_waddr_i = 5'd5;
    @(posedge clk_i); #1 valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1; we0 = we_cnt;
    if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
    #1;
    chk(use_rst ? "rst_stall" : "flush_stall", stallreq_o, 0);
    chk(use_rst ? "rst_busy" : "flush_busy_same", busy_o, use_rst ? 0 : 1);
    chk(use_rst ? "rst_outs" : "flush_outs", {reg_we_o, reg_waddr_o, reg_wdata_o}, 0);
    @(posedge clk_i); #1;
    if (!use_rst) chk("flush_idle_next", busy_o, 0);
    rst_i = 1'b0; flush_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #1;
    chk(use_rst ? "rst_no_we" : "flush_no_we", we_cnt, we0);
    chk("abort_busy_after", busy_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    inst_i = '0; op1_i = '0; op2_i = '0; reg_waddr_i = '0;
    #22;
    chk("reset_outs", {stallreq_o, busy_o, reg_we_o, reg_waddr_o, reg_wdata_o}, 0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op(3'd5, 32'd100, 32'd7, 5'd7);
    run_op(3'd7, 32'd100, 32'd7, 5'd8);
    run_op(3'd5, 32'd5, 32'd0, 5'd9);
    run_op(3'd7, 32'd5, 32'd0, 5'd10);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_op(3'd4, 32'd1234, 32'd0, 5'd13);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd0);

    abort_test(1'b1);
    abort_test(1'b0);

    // flush in the same cycle as a would-be start
    @(posedge clk_i); #1;
    valid_i = 1'b1; flush_i = 1'b1; inst_i = mk_inst(3'd5, 5'd3); op1_i = 32'd9; op2_i = 32'd3;
    #1 chk("flush_start_stall", stallreq_o, 0);
    @(posedge clk_i); #1 valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", busy_o, 0);

    // non-M instruction (ADD) is ignored
    @(posedge clk_i); #1;
    valid_i = 1'b1; inst_i = {7'b0000000, 5'd2, 5'd1, 3'd0, 5'd4, 7'b0110011};
    #1 chk("nonm_stall", stallreq_o, 0);
    @(posedge clk_i); #1 valid_i = 1'b0;
    chk("nonm_outs", {busy_o, reg_we_o, reg_wdata_o}, 0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = $urandom_range(0, 100);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 100);
        default: b = $urandom;
      endcase
      run_op(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
Iterative RV32M execute unit. Consumes the decoded instruction and forwarded operands from id_exe, and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. While busy it holds the pipeline through stallreq_o. On completion it presents the write-back triple (waddr/wdata/we) to mem and to the ID-stage forwarding inputs.

Parameters:
XLEN, 32, operand/result width (matches RDATA_WIDTH)
RADDR_W, 5, register address width (matches RADDR_WIDTH)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
valid_i  input  1  id_exe holds a live instruction this cycle
inst_i  input  32  instruction word from id_exe
op1_i  input  XLEN  rs1 value (already forwarded by ID)
op2_i  input  XLEN  rs2 value (already forwarded by ID)
reg_waddr_i  input  RADDR_W  destination register
flush_i  input  1  abort current op (branch/jump flush)
stallreq_o  output  1  hold IF/ID/id_exe
busy_o  output  1  state != IDLE
reg_we_o  output  1  write-back enable, 1-cycle pulse
reg_waddr_o  output  RADDR_W  write-back register
reg_wdata_o  output  XLEN  result

Behaviour:
- Clock is clk_i; reset is rst_i, asynchronous and active-high.
- Reset: state=IDLE, counter=0, all outputs 0. This applies at any time, including mid-CALC; partial state is discarded.
- Instruction is an M-op when opcode=0110011 and funct7=0000001. funct3 selects: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- start = valid_i & M-op & state==IDLE & !flush_i.
- stallreq_o = start | (state==CALC). This is combinational, so the stall is raised in the same cycle the op sits in id_exe.
- States:
  - IDLE: on start, latch funct3, waddr, |op1|, |op2| (absolute values for signed variants), and result sign flags.
    - Special cases go straight to DONE, with no CALC.
    - Otherwise go to CALC with count=0.
  - CALC, MUL*: shift-add, one multiplier bit per cycle, into a 2*XLEN accumulator.
  - CALC, DIV*/REM*: restoring radix-2, one quotient bit per cycle.
  - CALC exit: after XLEN iterations (count reaches XLEN-1), go to DONE.
  - DONE: apply sign correction and select the half/quotient/remainder. Drive reg_we_o=1, reg_waddr_o, reg_wdata_o for exactly one cycle, then return to IDLE.
- Latency: start at cycle T; CALC occupies T+1..T+XLEN; DONE at T+XLEN+1. stallreq_o is high T..T+XLEN and low at T+XLEN+1.
- Special cases: DONE at T+1, stallreq_o high only at T.
  - divisor=0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = op1.
  - signed overflow (op1=0x80000000, op2=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- Sign rules:
  - MULH: product negated if signs differ.
  - MULHSU: only op1 is treated as signed.
  - DIV: quotient sign = sign1 ^ sign2.
  - REM: remainder takes the sign of op1.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- flush_i in CALC or DONE: return to IDLE next cycle, no reg_we_o pulse, stallreq_o drops immediately.
- flush_i with start in the same cycle: flush wins, no op is accepted.
- x0 destination: the computation runs normally, but reg_we_o is forced to 0.
- Non-M instructions: ignored; outputs stay 0.

Optional Feature:
Macro MULDIV_FAST_MUL_EN.
- Defined: MUL* ops compute with a single-cycle combinational multiplier and go IDLE→DONE, with stallreq_o high only at cycle T. Divide behaviour is unchanged.
- Undefined: MUL* ops use the iterative XLEN-cycle path described above.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD -> reg_wdata_o=0xFFFFFFEB at T+33, stallreq_o high for 33 cycles (T+1 with MULDIV_FAST_MUL_EN).
- MULHU op1=op2=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU same operands -> 0xFFFFFFFF.
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same operands -> 0; all complete at T+1.
- Start DIV, assert rst_i at T+10 -> all outputs 0 immediately, no write. Repeat with flush_i at T+10 -> stallreq_o 0 that cycle, IDLE next cycle, reg_we_o never pulses.
- DIV with reg_waddr_i=0 -> full latency, reg_we_o stays 0. Back-to-back M-ops -> second accepted in the cycle after DONE, both results correct.
